// File: rtl/dec_pkg.sv
// Shared types and helpers for the scanning one-hot decoder family.
package dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MANUAL = 2'b01,
        ST_SCAN   = 2'b10
    } dec_state_e;

    // Widest select the onehot helper supports; callers truncate to 2**N.
    localparam int MAX_N   = 8;
    localparam int MAX_OUT = 1 << MAX_N;

    function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_N-1:0] idx);
        logic [MAX_OUT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dec_dwell_ctr.sv
// Dwell counter: counts cycles spent on a scan channel and flags when the
// programmed dwell has elapsed (tick), wrapping itself back to zero.
module dec_dwell_ctr #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    input  logic [DWELL_W-1:0] dwell,
    output logic               tick
);

    logic [DWELL_W-1:0] cnt;

    // >= rather than == so that shrinking dwell below cnt advances at once.
    assign tick = (cnt >= dwell);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tick ? '0 : cnt + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/dec_scan_nto2n.sv
// Registered N-to-2**N one-hot decoder with manual select and timed auto-scan.
// Define DEC_SKIP_MASK_EN to add a per-channel skip mask to the scan sequence.
module dec_scan_nto2n
    import dec_pkg::*;
#(
    parameter int N       = 2,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [N-1:0]       sel,
    input  logic               load,
    input  logic [DWELL_W-1:0] dwell,
`ifdef DEC_SKIP_MASK_EN
    input  logic [2**N-1:0]    mask,
`endif
    output logic [2**N-1:0]    y,
    output logic [N-1:0]       cur,
    output logic               wrap
);

    localparam int OUT_W = 1 << N;

    dec_state_e       state;
    logic [N-1:0]     cur_d;
    logic [OUT_W-1:0] y_d;
    logic             wrap_d;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             tick;
    logic [N-1:0]     adv_idx;
    logic             adv_wrap;
    logic             adv_ok;

    function automatic logic [OUT_W-1:0] decode(input logic [N-1:0] idx);
        return OUT_W'(onehot(MAX_N'(idx)));
    endfunction

    dec_dwell_ctr #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .dwell (dwell),
        .tick  (tick)
    );

`ifdef DEC_SKIP_MASK_EN
    // Circular search for the next unmasked channel above cur; landing at or
    // below cur means the search passed through index 0.
    always_comb begin
        logic [N-1:0] cand;
        cand     = '0;
        adv_idx  = cur;
        adv_wrap = 1'b0;
        adv_ok   = 1'b0;
        for (int k = 1; k <= OUT_W; k++) begin
            cand = cur + N'(k);
            if (!adv_ok && !mask[cand]) begin
                adv_ok   = 1'b1;
                adv_idx  = cand;
                adv_wrap = (cand <= cur);
            end
        end
    end
`else
    always_comb begin
        adv_idx  = cur + N'(1);
        adv_wrap = &cur;
        adv_ok   = 1'b1;
    end
`endif

    always_comb begin
        state = ST_IDLE;
        if (en) begin
            state = mode ? ST_SCAN : ST_MANUAL;
        end
    end

    always_comb begin
        cur_d   = cur;
        y_d     = '0;
        wrap_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            ST_MANUAL: begin
                cur_d   = sel;
                y_d     = decode(sel);
                cnt_clr = 1'b1;
            end
            ST_SCAN: begin
                if (load) begin
                    cur_d   = sel;
                    y_d     = decode(sel);
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                    if (tick && adv_ok) begin
                        cur_d  = adv_idx;
                        wrap_d = adv_wrap;
                    end
                    // adv_ok low means every channel is masked: blank output.
                    y_d = adv_ok ? decode(cur_d) : '0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y    <= '0;
            cur  <= '0;
            wrap <= 1'b0;
        end else begin
            y    <= y_d;
            cur  <= cur_d;
            wrap <= wrap_d;
        end
    end

endmodule
